// File: rtl/wb_pkg.sv
// Shared Wishbone constants and the initiator state encoding.
package wb_pkg;

  localparam int DataWidth = 32;
  localparam int SelWidth  = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_e;

  // Width of a counter that must reach `cycles`; never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    if (cycles > 32'sd0) begin
      return $clog2(cycles + 32'sd1);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/bus_master.sv
// Single-outstanding Wishbone pipelined initiator with stall handling and a
// bus timeout. Client side is valid/ready in, one-cycle response pulse out.
module bus_master
  import wb_pkg::*;
#(
  parameter int AddrWidth     = 30,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_data,
  input  logic [SelWidth-1:0]  req_sel,
  output logic                 resp_valid,
  output logic [DataWidth-1:0] resp_data,
  output logic                 resp_err,
  output logic                 resp_timeout,
  input  logic [DataWidth-1:0] bus_data_s,
  input  logic                 bus_ack,
  input  logic                 bus_stall,
  input  logic                 bus_err,
  output logic [DataWidth-1:0] bus_data_m,
  output logic [AddrWidth-1:0] bus_addr,
  output logic [SelWidth-1:0]  bus_sel,
  output logic                 bus_cyc,
  output logic                 bus_stb,
  output logic                 bus_we
);

  localparam int                   CntWidth   = cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0]  TimeoutVal = CntWidth'(TimeoutCycles);
  localparam logic [CntWidth-1:0]  CntOne     = CntWidth'(1);
  localparam logic                 TimeoutOn  = (TimeoutCycles != 32'sd0);

  wb_state_e              r_state;
  logic [CntWidth-1:0]    r_cnt;
  logic                   r_cyc;
  logic                   r_stb;
  logic                   r_we;
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_data;
  logic [SelWidth-1:0]    r_sel;
  logic                   r_resp_valid;
  logic [DataWidth-1:0]   r_resp_data;
  logic                   r_resp_err;
  logic                   r_resp_timeout;

  wb_state_e              w_state_nxt;
  logic [CntWidth-1:0]    w_cnt_nxt;
  logic                   w_cyc_nxt;
  logic                   w_stb_nxt;
  logic                   w_we_nxt;
  logic [AddrWidth-1:0]   w_addr_nxt;
  logic [DataWidth-1:0]   w_data_nxt;
  logic [SelWidth-1:0]    w_sel_nxt;
  logic                   w_resp_valid_nxt;
  logic [DataWidth-1:0]   w_resp_data_nxt;
  logic                   w_resp_err_nxt;
  logic                   w_resp_timeout_nxt;

  logic                   w_active;
  logic                   w_strobe_taken;
  logic                   w_done;
  logic [CntWidth-1:0]    w_cnt_inc;
  logic                   w_expired;

  // Completion can only be honoured once the strobe has been taken by the slave;
  // the timeout fires on the cycle whose increment reaches the limit.
  assign w_active       = (r_state == REQ) || (r_state == WAIT);
  assign w_strobe_taken = (r_state == WAIT) || ((r_state == REQ) && !bus_stall);
  assign w_done         = w_strobe_taken && (bus_ack || bus_err);
  assign w_cnt_inc      = r_cnt + CntOne;
  assign w_expired      = TimeoutOn && w_active && (w_cnt_inc == TimeoutVal);

  assign req_ready    = (r_state == IDLE) && !rst;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_err     = r_resp_err;
  assign resp_timeout = r_resp_timeout;
  assign bus_cyc      = r_cyc;
  assign bus_stb      = r_stb;
  assign bus_we       = r_we;
  assign bus_addr     = r_addr;
  assign bus_data_m   = r_data;
  assign bus_sel      = r_sel;

  // Next-state and next-output decode; bus fields default to zero (idle value).
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_cyc_nxt          = 1'b0;
    w_stb_nxt          = 1'b0;
    w_we_nxt           = 1'b0;
    w_addr_nxt         = {AddrWidth{1'b0}};
    w_data_nxt         = {DataWidth{1'b0}};
    w_sel_nxt          = {SelWidth{1'b0}};
    w_resp_valid_nxt   = 1'b0;
    w_resp_data_nxt    = {DataWidth{1'b0}};
    w_resp_err_nxt     = 1'b0;
    w_resp_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = REQ;
          w_cnt_nxt   = {CntWidth{1'b0}};
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_we_nxt    = req_we;
          w_addr_nxt  = req_addr;
          w_data_nxt  = req_data;
          w_sel_nxt   = req_sel;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ, WAIT: begin
        if (w_done) begin
          // Slave answered: err beats ack, read data only on a clean read.
          w_state_nxt      = IDLE;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = bus_err;
          if (!r_we && !bus_err) begin
            w_resp_data_nxt = bus_data_s;
          end else begin
            w_resp_data_nxt = {DataWidth{1'b0}};
          end
        end else if (w_expired) begin
          w_state_nxt        = IDLE;
          w_resp_valid_nxt   = 1'b1;
          w_resp_err_nxt     = 1'b1;
          w_resp_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_cyc_nxt  = 1'b1;
          w_we_nxt   = r_we;
          w_addr_nxt = r_addr;
          w_data_nxt = r_data;
          w_sel_nxt  = r_sel;
          if ((r_state == REQ) && bus_stall) begin
            w_stb_nxt   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = WAIT;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= {CntWidth{1'b0}};
      r_cyc          <= 1'b0;
      r_stb          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= {AddrWidth{1'b0}};
      r_data         <= {DataWidth{1'b0}};
      r_sel          <= {SelWidth{1'b0}};
      r_resp_valid   <= 1'b0;
      r_resp_data    <= {DataWidth{1'b0}};
      r_resp_err     <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_cyc          <= w_cyc_nxt;
      r_stb          <= w_stb_nxt;
      r_we           <= w_we_nxt;
      r_addr         <= w_addr_nxt;
      r_data         <= w_data_nxt;
      r_sel          <= w_sel_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_data    <= w_resp_data_nxt;
      r_resp_err     <= w_resp_err_nxt;
      r_resp_timeout <= w_resp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: a transaction-level timeline model paints the expected
// value of every output for every cycle; a reactive slave answers the bus.
module tb_bus_master;

  localparam int AW = 30;
  localparam int TO = 8;
  localparam int NC = 82;
  localparam int NV = 13;
  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_ERR  = 2;
  localparam int K_BOTH = 3;

  typedef struct {
    int          gap;
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          s;
    int          d;
    int          kind;
    int          rst_at;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [29:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_sel;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] bus_data_s;
  logic        bus_ack;
  logic        bus_stall;
  logic        bus_err;
  logic [31:0] bus_data_m;
  logic [29:0] bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;

  bus_master #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_timeout(resp_timeout),
    .bus_data_s(bus_data_s), .bus_ack(bus_ack), .bus_stall(bus_stall),
    .bus_err(bus_err), .bus_data_m(bus_data_m), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we)
  );

  vec_t        vt [NV];
  int          pa [NV];
  int          pp [NV];
  // expected per-cycle outputs
  logic        e_ready [NC];
  logic        e_cyc   [NC];
  logic        e_stb   [NC];
  logic        e_we    [NC];
  logic [29:0] e_addr  [NC];
  logic [31:0] e_data  [NC];
  logic [3:0]  e_sel   [NC];
  logic        e_rv    [NC];
  logic [31:0] e_rdata [NC];
  logic        e_err   [NC];
  logic        e_to    [NC];
  logic        e_chk   [NC];
  // per-cycle stimulus
  logic        d_rst   [NC];
  logic        d_valid [NC];
  logic        d_we    [NC];
  logic [29:0] d_addr  [NC];
  logic [31:0] d_data  [NC];
  logic [3:0]  d_sel   [NC];

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int obs_cycle[$];
  logic [31:0] obs_data[$];
  int obs_to = 0;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    if (a == 30'd4) return 32'hDEADBEEF;
    else return 32'h5A000000 ^ {2'b00, a};
  endfunction

  task automatic chk(input string nm, input int n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask

  task automatic build_model();
    int free, a, acc, r, done, p, prev_a, start, stb_end;
    logic to;
    vt[0]  = '{1, 1'b0, 30'h4,        32'h0,        4'hF, 0,  1, K_ACK,  0};
    vt[1]  = '{2, 1'b1, 30'h10,       32'h12345678, 4'hF, 3,  1, K_ACK,  0};
    vt[2]  = '{1, 1'b0, 30'h20,       32'h0,        4'hF, 0,  1, K_ERR,  0};
    vt[3]  = '{1, 1'b0, 30'h30,       32'h0,        4'hF, 0,  0, K_NONE, 0};
    vt[4]  = '{1, 1'b0, 30'h4,        32'h0,        4'hF, 0,  1, K_ACK,  0};
    vt[5]  = '{0, 1'b0, 30'h5,        32'h0,        4'h3, 0,  1, K_ACK,  0};
    vt[6]  = '{0, 1'b0, 30'h6,        32'h0,        4'hC, 0,  1, K_ACK,  0};
    vt[7]  = '{0, 1'b1, 30'h3FFFFFFF, 32'hFFFFFFFF, 4'h5, 0,  0, K_ACK,  0};
    vt[8]  = '{1, 1'b0, 30'h7,        32'h0,        4'hF, 0,  7, K_ACK,  0};
    vt[9]  = '{1, 1'b0, 30'h8,        32'h0,        4'hF, 1,  0, K_BOTH, 0};
    vt[10] = '{1, 1'b0, 30'h9,        32'h0,        4'hF, 10, 0, K_ACK,  0};
    vt[11] = '{1, 1'b0, 30'hA,        32'h0,        4'hF, 0,  0, K_NONE, 3};
    vt[12] = '{0, 1'b0, 30'h4,        32'h0,        4'hF, 0,  1, K_ACK,  0};
    for (int n = 0; n < NC; n++) begin
      e_ready[n] = 1'b1; e_cyc[n] = 1'b0; e_stb[n] = 1'b0; e_we[n] = 1'b0;
      e_addr[n] = 30'h0; e_data[n] = 32'h0; e_sel[n] = 4'h0; e_rv[n] = 1'b0;
      e_rdata[n] = 32'h0; e_err[n] = 1'b0; e_to[n] = 1'b0; e_chk[n] = 1'b0;
      d_rst[n] = 1'b0; d_valid[n] = 1'b0; d_we[n] = 1'b1;
      d_addr[n] = 30'(n + 1); d_data[n] = 32'h0BAD0000 | 32'(n); d_sel[n] = 4'hA;
    end
    for (int n = 0; n < 3; n++) begin d_rst[n] = 1'b1; e_ready[n] = 1'b0; end
    for (int n = 1; n < 4; n++) e_chk[n] = 1'b1;
    free = 3;
    prev_a = 0;
    for (int i = 0; i < NV; i++) begin
      a = free + vt[i].gap;
      start = (vt[i].gap == 0) ? prev_a + 1 : a;
      for (int n = start; n <= a; n++) begin
        d_valid[n] = 1'b1; d_we[n] = vt[i].we; d_addr[n] = vt[i].addr;
        d_data[n] = vt[i].data; d_sel[n] = vt[i].sel;
      end
      pa[i] = a;
      acc = a + 1 + vt[i].s;
      r = acc + vt[i].d;
      if (vt[i].rst_at > 0) begin
        done = a + vt[i].rst_at;
        to = 1'b0;
      end else if (vt[i].kind != K_NONE && r <= a + TO) begin
        done = r;
        to = 1'b0;
      end else begin
        done = a + TO;
        to = 1'b1;
      end
      stb_end = (acc < done) ? acc : done;
      for (int n = a + 1; n <= done; n++) begin
        e_cyc[n] = 1'b1; e_ready[n] = 1'b0;
      end
      for (int n = a + 1; n <= stb_end; n++) begin
        e_stb[n] = 1'b1; e_we[n] = vt[i].we; e_addr[n] = vt[i].addr;
        e_data[n] = vt[i].data; e_sel[n] = vt[i].sel;
      end
      if (vt[i].rst_at > 0) begin
        d_rst[done] = 1'b1; d_rst[done + 1] = 1'b1;
        e_ready[done + 1] = 1'b0;
        e_chk[done + 1] = 1'b1; e_chk[done + 2] = 1'b1;
        free = done + 2;
        pp[i] = -1;
      end else begin
        p = done + 1;
        e_rv[p] = 1'b1;
        e_to[p] = to;
        e_err[p] = to || vt[i].kind == K_ERR || vt[i].kind == K_BOTH;
        e_rdata[p] = (!to && vt[i].kind == K_ACK && !vt[i].we) ? rom_word(vt[i].addr) : 32'h0;
        free = p;
        pp[i] = p;
      end
      prev_a = a;
    end
  endtask

  task automatic drive(input int n);
    rst = d_rst[n]; req_valid = d_valid[n]; req_we = d_we[n];
    req_addr = d_addr[n]; req_data = d_data[n]; req_sel = d_sel[n];
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reactive slave: stalls, then answers after a delay, per transaction entry.
  initial begin
    int sx, sk, sw, ix;
    logic prev_cyc;
    logic [29:0] saddr;
    logic swe;
    sx = -1; sk = 0; sw = -1; prev_cyc = 1'b0; saddr = 30'h0; swe = 1'b0;
    bus_stall = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_data_s = 32'h0;
    forever begin
      @(negedge clk);
      bus_stall = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_data_s = 32'hCAFEF00D;
      if (bus_cyc !== 1'b1) begin
        bus_ack = 1'b1; bus_err = 1'b1; sk = 0; sw = -1;
      end else begin
        if (!prev_cyc) begin sx++; saddr = bus_addr; swe = bus_we; end
        ix = (sx < NV) ? sx : NV - 1;
        if (bus_stb === 1'b1 && sk < vt[ix].s) begin
          bus_stall = 1'b1; sk++;
        end else begin
          sw = (bus_stb === 1'b1) ? 0 : sw + 1;
          if (sw == vt[ix].d) begin
            if (vt[ix].kind == K_ACK) begin
              bus_ack = 1'b1;
              if (!swe) bus_data_s = rom_word(saddr);
            end else if (vt[ix].kind == K_ERR) begin
              bus_err = 1'b1;
            end else if (vt[ix].kind == K_BOTH) begin
              bus_ack = 1'b1; bus_err = 1'b1;
            end
          end
        end
      end
      prev_cyc = (bus_cyc === 1'b1);
    end
  end

  // Compare every cycle against the painted timeline.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc_n >= 1 && cyc_n <= NC - 2) begin
        chk("req_ready", cyc_n, 64'(req_ready), 64'(e_ready[cyc_n]));
        chk("bus_cyc", cyc_n, 64'(bus_cyc), 64'(e_cyc[cyc_n]));
        chk("bus_stb", cyc_n, 64'(bus_stb), 64'(e_stb[cyc_n]));
        chk("resp_valid", cyc_n, 64'(resp_valid), 64'(e_rv[cyc_n]));
        if (e_stb[cyc_n] || e_chk[cyc_n]) begin
          chk("bus_we", cyc_n, 64'(bus_we), 64'(e_we[cyc_n]));
          chk("bus_addr", cyc_n, 64'(bus_addr), 64'(e_addr[cyc_n]));
          chk("bus_data_m", cyc_n, 64'(bus_data_m), 64'(e_data[cyc_n]));
          chk("bus_sel", cyc_n, 64'(bus_sel), 64'(e_sel[cyc_n]));
        end
        if (e_rv[cyc_n] || e_chk[cyc_n]) begin
          chk("resp_data", cyc_n, 64'(resp_data), 64'(e_rdata[cyc_n]));
          chk("resp_err", cyc_n, 64'(resp_err), 64'(e_err[cyc_n]));
          chk("resp_timeout", cyc_n, 64'(resp_timeout), 64'(e_to[cyc_n]));
        end
        if (resp_valid === 1'b1) begin
          obs_cycle.push_back(cyc_n);
          obs_data.push_back(resp_data);
          if (resp_timeout === 1'b1) obs_to++;
        end
      end
    end
  end

  initial begin
    build_model();
    chk("pin_first_accept", -1, 64'(pa[0]), 64'd4);
    chk("pin_read_latency", -1, 64'(pp[0] - pa[0]), 64'd3);
    chk("pin_stall_resp", -1, 64'(pp[1]), 64'd15);
    chk("pin_timeout_latency", -1, 64'(pp[3] - pa[3]), 64'd9);
    chk("pin_b2b_period", -1, 64'(pp[6] - pp[5]), 64'd3);
    chk("pin_ack_at_limit", -1, 64'(e_to[pp[8]]), 64'd0);
    chk("pin_accept_after_rst", -1, 64'(pa[12]), 64'd71);
    cyc_n = 0;
    drive(0);
    while (cyc_n < NC - 1) begin
      @(posedge clk);
      cyc_n++;
      #1 drive(cyc_n);
    end
    chk("obs_resp_count", -1, 64'(obs_cycle.size()), 64'd12);
    chk("obs_timeout_count", -1, 64'(obs_to), 64'd2);
    if (obs_cycle.size() >= 2) begin
      chk("obs_first_resp_cycle", -1, 64'(obs_cycle[0]), 64'd7);
      chk("obs_first_resp_data", -1, 64'(obs_data[0]), 64'hDEADBEEF);
      chk("obs_write_resp_cycle", -1, 64'(obs_cycle[1]), 64'd15);
    end else begin
      chk("obs_resp_present", -1, 64'(obs_cycle.size()), 64'd2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
